zbt_point_arbiter: RTL and testbench

ZBT_POINT_ARBITER -- requirements
Module: zbt_point_arbiter

---
 rtl/zbt_point_arbiter.sv | 96 +++++++++
 tb/tb_zbt_point_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/zbt_point_arbiter.sv
// Round-robin arbiter sharing one ZBT SRAM port between a point-capture writer
// and a renderer reader, with lagged write data and tagged read-return pipeline.
module zbt_point_arbiter #(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned AW           = 19
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [35:0]   wr_data,
  output logic          wr_ack,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_ack,
  output logic          rd_valid,
  output logic [35:0]   rd_data,
  output logic [AW-1:0] zbt0_addr,
  output logic          zbt0_we,
  output logic [35:0]   zbt0_write_data,
  input  logic [35:0]   zbt0_read_data
);

  localparam logic [0:0]  GRANT_WR = 1'b0;
  localparam logic [0:0]  GRANT_RD = 1'b1;
  localparam int unsigned NS       = READ_LATENCY + 1;

  logic [0:0]    last_grant_d, last_grant_q;
  logic [AW-1:0] addr_d, addr_q;
  logic          we_d, we_q;
  logic [NS-1:0] wv_d, wv_q;
  logic [35:0]   wd_d [NS];
  logic [35:0]   wd_q [NS];
  logic [NS-1:0] tag_d, tag_q;
  logic          rdv_d, rdv_q;
  logic [35:0]   rdd_d, rdd_q;

  always_comb begin
    wr_ack = reset_n & wr_req & (~rd_req | (last_grant_q == GRANT_RD));
    rd_ack = reset_n & rd_req & ~wr_ack;

    last_grant_d = last_grant_q;
    if (wr_ack)      last_grant_d = GRANT_WR;
    else if (rd_ack) last_grant_d = GRANT_RD;

    we_d   = wr_ack;
    addr_d = addr_q;
    if (wr_ack)      addr_d = wr_addr;
    else if (rd_ack) addr_d = rd_addr;

    // Stages only capture when a valid write shifts in, so the last stage
    // doubles as the held zbt0_write_data output.
    wv_d     = '0;
    tag_d    = '0;
    wv_d[0]  = wr_ack;
    tag_d[0] = rd_ack;
    wd_d[0]  = wr_ack ? wr_data : wd_q[0];
    for (int unsigned i = 1; i < NS; i++) begin
      wv_d[i]  = wv_q[i-1];
      tag_d[i] = tag_q[i-1];
      wd_d[i]  = wv_q[i-1] ? wd_q[i-1] : wd_q[i];
    end

    rdv_d = tag_q[NS-1];
    rdd_d = tag_q[NS-1] ? zbt0_read_data : rdd_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= GRANT_RD;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wv_q         <= '0;
      tag_q        <= '0;
      rdv_q        <= 1'b0;
      rdd_q        <= '0;
      for (int unsigned i = 0; i < NS; i++) wd_q[i] <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wv_q         <= wv_d;
      tag_q        <= tag_d;
      rdv_q        <= rdv_d;
      rdd_q        <= rdd_d;
      for (int unsigned i = 0; i < NS; i++) wd_q[i] <= wd_d[i];
    end
  end

  assign zbt0_addr       = addr_q;
  assign zbt0_we         = we_q;
  assign zbt0_write_data = wd_q[NS-1];
  assign rd_valid        = rdv_q;
  assign rd_data         = rdd_q;

endmodule

// File: tb/tb_zbt_point_arbiter.sv
// Bench for zbt_point_arbiter: directed and random requests checked against a
// cycle-scheduled reference model of grants, ZBT port activity and read returns.
`timescale 1ns/1ps
module tb_zbt_point_arbiter;
  localparam int unsigned RL = 2;
  localparam int unsigned AW = 19;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_req, rd_req;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [35:0]   wr_data;
  logic          wr_ack, rd_ack, rd_valid, zbt0_we;
  logic [35:0]   rd_data, zbt0_write_data, zbt0_read_data;
  logic [AW-1:0] zbt0_addr;

  zbt_point_arbiter #(.READ_LATENCY(RL), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .zbt0_addr(zbt0_addr), .zbt0_we(zbt0_we), .zbt0_write_data(zbt0_write_data),
    .zbt0_read_data(zbt0_read_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_assert = 0;
  int n_fail   = 0;
  int ovr_cyc  = -1;

  // Expected events keyed by the absolute cycle in which they become visible.
  bit            sch_we   [int];
  logic [AW-1:0] sch_addr [int];
  logic [35:0]   sch_wd   [int];
  logic [35:0]   sch_rd   [int];
  logic          e_we, e_rdv;
  logic [AW-1:0] e_addr;
  logic [35:0]   e_wd, e_rdd;
  bit            last_was_rd;

  function automatic logic [35:0] rdata(input int c);
    logic [31:0] cu;
    cu = c;
    if (c == ovr_cyc) return 36'h123456789;
    return {cu[3:0], cu * 32'h9E3779B9};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    sch_we.delete(); sch_addr.delete(); sch_wd.delete(); sch_rd.delete();
    e_we = 1'b0; e_rdv = 1'b0; e_addr = '0; e_wd = '0; e_rdd = '0;
    last_was_rd = 1'b1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wr_ack"}, 64'(wr_ack), 64'd0);
    chk({tag, "_rd_ack"}, 64'(rd_ack), 64'd0);
    chk({tag, "_we"},     64'(zbt0_we), 64'd0);
    chk({tag, "_addr"},   64'(zbt0_addr), 64'd0);
    chk({tag, "_wdata"},  64'(zbt0_write_data), 64'd0);
    chk({tag, "_rdv"},    64'(rd_valid), 64'd0);
    chk({tag, "_rdd"},    64'(rd_data), 64'd0);
  endtask

  // One clock cycle: drive requests, check every output mid-cycle, then
  // schedule the consequences of whatever the model says is granted.
  task automatic step(input logic wr, input logic [AW-1:0] wa, input logic [35:0] wd,
                      input logic rd, input logic [AW-1:0] ra);
    int  c;
    bit  gw, gr;
    wr_req = wr; wr_addr = wa; wr_data = wd;
    rd_req = rd; rd_addr = ra;
    zbt0_read_data = rdata(cyc);
    @(negedge clk);
    c  = cyc;
    gw = wr && (!rd || last_was_rd);
    gr = rd && !gw;
    e_we = sch_addr.exists(c) ? sch_we[c] : 1'b0;
    if (sch_addr.exists(c)) e_addr = sch_addr[c];
    if (sch_wd.exists(c))   e_wd   = sch_wd[c];
    e_rdv = sch_rd.exists(c);
    if (e_rdv) e_rdd = sch_rd[c];
    chk("wr_ack",   64'(wr_ack), 64'(gw));
    chk("rd_ack",   64'(rd_ack), 64'(gr));
    chk("zbt_we",   64'(zbt0_we), 64'(e_we));
    chk("zbt_addr", 64'(zbt0_addr), 64'(e_addr));
    chk("zbt_wdat", 64'(zbt0_write_data), 64'(e_wd));
    chk("rd_valid", 64'(rd_valid), 64'(e_rdv));
    chk("rd_data",  64'(rd_data), 64'(e_rdd));
    if (gw) begin
      sch_we[c+1] = 1'b1; sch_addr[c+1] = wa; sch_wd[c+1+RL] = wd;
      last_was_rd = 1'b0;
    end else if (gr) begin
      sch_we[c+1] = 1'b0; sch_addr[c+1] = ra;
      sch_rd[c+2+RL] = rdata(c + 1 + RL);
      last_was_rd = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    wr_req = 1'b1; rd_req = 1'b1; wr_addr = '0; rd_addr = '0; wr_data = '0;
    zbt0_read_data = '0;
    model_reset();
    #3;
    chk_reset_state("por");
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    // Simultaneous first requests: write wins, read follows next cycle.
    step(1, 19'h00011, 36'h0AAAA5555, 1, 19'h00022);
    step(0, '0, '0, 1, 19'h00022);
    step(0, '0, '0, 0, '0);
    step(0, '0, '0, 0, '0);

    // Single read returning a fixed word from the memory side.
    ovr_cyc = cyc + 1 + RL;
    step(0, '0, '0, 1, 19'h00005);
    for (int i = 0; i < 5; i++) step(0, '0, '0, 0, '0);

    // Extreme address/data write.
    step(1, 19'h7FFFF, 36'hFFFFFFFFF, 0, '0);
    for (int i = 0; i < 4; i++) step(0, '0, '0, 0, '0);

    // Sustained contention for 8 cycles.
    for (int i = 0; i < 8; i++)
      step(1, 19'(i + 19'h100), 36'(i) * 36'h111111111, 1, 19'(i + 19'h200));
    for (int i = 0; i < 5; i++) step(0, '0, '0, 0, '0);

    // Idle window: address must hold, no strobes.
    for (int i = 0; i < 10; i++) step(0, '0, '0, 0, '0);

    // Random traffic, including dropped requests.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 19'($urandom), {4'($urandom), 32'($urandom)},
           1'($urandom_range(0, 1)), 19'($urandom));

    // Two reads in flight, then reset: their returns must vanish.
    step(0, '0, '0, 1, 19'h00033);
    step(0, '0, '0, 1, 19'h00044);
    reset_n = 1'b0;
    wr_req = 1'b1; rd_req = 1'b1;
    #1;
    chk_reset_state("mid_rst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    step(1, 19'h00055, 36'h00000BEEF, 1, 19'h00066);
    for (int i = 0; i < 8; i++) step(0, '0, '0, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
